// File: rtl/feature_stream_tx.sv
// feature_stream_tx: source end of the group stream protocol.
// Collects one row of feature words from a valid/ready producer into a row
// buffer, then replays it as a framed burst (vsync per frame, hsync per row,
// GAP idle cycles, ROWLEN valid words).
// Optional feature macro: FEATURE_TX_REUSE_EN replays every row a second
// time with o_reuse high; without it o_reuse stays 0.
module feature_stream_tx #(
  parameter int         WIDTH_D = 27,
  parameter int         SIZE    = 28,
  parameter int         CHANNEL = 128,
  parameter logic [3:0] GAP     = 4'd0
) (
  input  logic               i_sclk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_valid,
  input  logic [WIDTH_D-1:0] i_tdata,
  output logic               o_ready,
  output logic               o_vsync,
  output logic               o_hsync,
  output logic               o_reuse,
  output logic               o_valid,
  output logic [WIDTH_D-1:0] o_tdata,
  output logic               o_busy,
  output logic               o_done
);

  localparam int ROWLEN = SIZE * CHANNEL;
  localparam int PW     = (ROWLEN > 1) ? $clog2(ROWLEN) : 1;
  localparam int RW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(ROWLEN - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SIZE - 1);

`ifdef FEATURE_TX_REUSE_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, VS = 3'd1, FILL = 3'd2, HS = 3'd3,
    GAP_ST = 3'd4, SEND = 3'd5, FIN = 3'd6, REUSE = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, VS = 3'd1, FILL = 3'd2, HS = 3'd3,
    GAP_ST = 3'd4, SEND = 3'd5, FIN = 3'd6
  } state_t;
`endif

  state_t             state;
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [RW-1:0]      row;
  logic [3:0]         gap_cnt;
  logic [WIDTH_D-1:0] mem [ROWLEN];
`ifdef FEATURE_TX_REUSE_EN
  logic               second_pass;
`endif

  // Row buffer write port: store every word accepted during FILL.
  always_ff @(posedge i_sclk) begin
    if (i_rst_n && (state == FILL) && o_ready && i_valid) begin
      mem[wptr] <= i_tdata;
    end
  end

  // Frame sequencer with registered outputs; read port is folded in so the
  // RAM latency lines data up with o_valid.
  always_ff @(posedge i_sclk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      row     <= '0;
      gap_cnt <= 4'd0;
      o_ready <= 1'b0;
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_reuse <= 1'b0;
      o_valid <= 1'b0;
      o_tdata <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
`ifdef FEATURE_TX_REUSE_EN
      second_pass <= 1'b0;
`endif
    end else begin
      // Pulses and the data bus default low; states below raise them.
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_valid <= 1'b0;
      o_tdata <= '0;
      o_done  <= 1'b0;
      case (state)
        IDLE: begin
          o_ready <= 1'b0;
          if (i_start) begin
            o_vsync <= 1'b1;
            o_busy  <= 1'b1;
            state   <= VS;
          end else begin
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
        VS: begin
          row   <= '0;
          wptr  <= '0;
          state <= FILL;
        end
        FILL: begin
          o_reuse <= 1'b0;
          if (o_ready && i_valid) begin
            if (wptr == PTR_LAST) begin
              // Last word of the row: stop taking words, announce the row.
              wptr    <= '0;
              o_ready <= 1'b0;
              o_hsync <= 1'b1;
              state   <= HS;
            end else begin
              wptr    <= wptr + 1'b1;
              o_ready <= 1'b1;
            end
          end else begin
            o_ready <= 1'b1;
          end
        end
        HS: begin
          rptr <= '0;
          if (GAP == 4'd0) begin
            state <= SEND;
          end else begin
            gap_cnt <= 4'd0;
            state   <= GAP_ST;
          end
        end
        GAP_ST: begin
          if (gap_cnt == (GAP - 4'd1)) begin
            gap_cnt <= 4'd0;
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        SEND: begin
          o_valid <= 1'b1;
          o_tdata <= mem[rptr];
          if (rptr == PTR_LAST) begin
            rptr <= '0;
`ifdef FEATURE_TX_REUSE_EN
            if (!second_pass) begin
              second_pass <= 1'b1;
              state       <= REUSE;
            end else begin
              second_pass <= 1'b0;
              if (row == ROW_LAST) begin
                state <= FIN;
              end else begin
                row   <= row + 1'b1;
                state <= FILL;
              end
            end
`else
            if (row == ROW_LAST) begin
              state <= FIN;
            end else begin
              row   <= row + 1'b1;
              state <= FILL;
            end
`endif
          end else begin
            rptr <= rptr + 1'b1;
          end
        end
`ifdef FEATURE_TX_REUSE_EN
        REUSE: begin
          // Last first-pass word is on the bus now; hsync follows next cycle.
          o_hsync <= 1'b1;
          o_reuse <= 1'b1;
          state   <= HS;
        end
`endif
        FIN: begin
          o_reuse <= 1'b0;
          o_done  <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_stream_tx.sv
// Bench for feature_stream_tx: SIZE=4, CHANNEL=2 (ROWLEN=8). Instance a uses
// GAP=2, instance b uses GAP=0; one producer drives whichever is selected.
module tb_feature_stream_tx;

  localparam int W      = 27;
  localparam int ROWLEN = 8;
  localparam int NROWS  = 4;
  localparam int TOTAL  = ROWLEN * NROWS;
`ifdef FEATURE_TX_REUSE_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic a_ready, a_vsync, a_hsync, a_reuse, a_valid, a_busy, a_done;
  logic b_ready, b_vsync, b_hsync, b_reuse, b_valid, b_busy, b_done;
  logic [W-1:0] a_tdata, b_tdata;

  wire ready = sel ? b_ready : a_ready;
  wire vsync = sel ? b_vsync : a_vsync;
  wire hsync = sel ? b_hsync : a_hsync;
  wire reuse = sel ? b_reuse : a_reuse;
  wire valid = sel ? b_valid : a_valid;
  wire busy  = sel ? b_busy  : a_busy;
  wire done  = sel ? b_done  : a_done;
  wire [W-1:0] tdata = sel ? b_tdata : a_tdata;

  feature_stream_tx #(.WIDTH_D(W), .SIZE(4), .CHANNEL(2), .GAP(4'd2)) dut_a (
    .i_sclk(clk), .i_rst_n(rst_n), .i_start(start & ~sel),
    .i_valid(in_valid & ~sel), .i_tdata(in_data),
    .o_ready(a_ready), .o_vsync(a_vsync), .o_hsync(a_hsync), .o_reuse(a_reuse),
    .o_valid(a_valid), .o_tdata(a_tdata), .o_busy(a_busy), .o_done(a_done)
  );

  feature_stream_tx #(.WIDTH_D(W), .SIZE(4), .CHANNEL(2), .GAP(4'd0)) dut_b (
    .i_sclk(clk), .i_rst_n(rst_n), .i_start(start & sel),
    .i_valid(in_valid & sel), .i_tdata(in_data),
    .o_ready(b_ready), .o_vsync(b_vsync), .o_hsync(b_hsync), .o_reuse(b_reuse),
    .o_valid(b_valid), .o_tdata(b_tdata), .o_busy(b_busy), .o_done(b_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observed stream, recorded once per cycle on the falling edge.
  int mcyc = 0, n_vs = 0, n_done = 0, n_excl = 0, n_rv = 0, n_tz = 0;
  int hs_t[$];
  int vt[$];
  logic [W-1:0] vd[$];
  bit vr[$];
  logic [W-1:0] words [TOTAL];

  always @(negedge clk) begin
    mcyc++;
    if (vsync) n_vs++;
    if (hsync) hs_t.push_back(mcyc);
    if (valid) begin
      vd.push_back(tdata);
      vr.push_back(reuse);
      vt.push_back(mcyc);
    end
    if (done) n_done++;
    if ((int'(vsync) + int'(hsync) + int'(valid)) > 1) n_excl++;
    if (ready && valid) n_rv++;
    if (!valid && (tdata != '0)) n_tz++;
  end

  task automatic mon_clear();
    @(posedge clk);
    #1;
    n_vs = 0; n_done = 0; n_excl = 0; n_rv = 0; n_tz = 0;
    hs_t.delete(); vt.delete(); vd.delete(); vr.delete();
  endtask

  // Expected word for the i-th output beat: rows in order, each row PASSES times.
  function automatic logic [W-1:0] exp_word(input int i);
    return words[(i / (ROWLEN * PASSES)) * ROWLEN + (i % ROWLEN)];
  endfunction

  // One frame: fresh random words, start pulse, producer until done.
  task automatic run_frame(input bit bp, input int ign_at);
    int idx = 0;
    int cyc = 0;
    mon_clear();
    for (int k = 0; k < TOTAL; k++) words[k] = W'($urandom);
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
    while ((idx < TOTAL || n_done == 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == ign_at);
      if (idx < TOTAL) begin
        in_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = words[idx];
        if (in_valid && ready) idx++;
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (cyc >= 3000) begin
      checks++; errors++;
      $display("FAIL frame_timeout: accepted=%0d done=%0d, required %0d words and done", idx, n_done, TOTAL);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    int cyc = 0;
    int idx = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_ready, a_vsync, a_hsync, a_reuse, a_valid, a_tdata, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL reset_init: outputs=%h, required 0", {a_ready, a_vsync, a_hsync, a_reuse, a_valid, a_tdata, a_busy, a_done});
    end
    rst_n = 1'b1;
    // Start a frame, fill one row, and reset once its replay is under way.
    mon_clear();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while ((idx < ROWLEN || vd.size() == 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      in_valid = (idx < ROWLEN);
      in_data  = W'(idx + 1);
      if (in_valid && ready) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (vd.size() == 0) begin
      errors++;
      $display("FAIL reset_reach_send: valid beats=0, required >0");
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ready, a_vsync, a_hsync, a_reuse, a_valid, a_tdata, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_send: outputs=%h, required 0", {a_ready, a_vsync, a_hsync, a_reuse, a_valid, a_tdata, a_busy, a_done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: busy=%b, required 0", a_busy);
    end
  endtask

  task automatic test_full_frame();
    sel = 1'b0;
    run_frame(1'b0, -1);
    checks++;
    if (n_vs != 1) begin errors++; $display("FAIL full_vsync: count=%0d, required 1", n_vs); end
    checks++;
    if (hs_t.size() != NROWS * PASSES) begin
      errors++; $display("FAIL full_hsync: count=%0d, required %0d", hs_t.size(), NROWS * PASSES);
    end
    checks++;
    if (vd.size() != TOTAL * PASSES) begin
      errors++; $display("FAIL full_valid: count=%0d, required %0d", vd.size(), TOTAL * PASSES);
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL full_done: count=%0d, required 1", n_done); end
    for (int i = 0; i < vd.size() && i < TOTAL * PASSES; i++) begin
      checks++;
      if (vd[i] !== exp_word(i)) begin
        errors++; $display("FAIL full_word[%0d]: got=%h, required %h", i, vd[i], exp_word(i));
      end
    end
    for (int h = 0; h < hs_t.size() && h * ROWLEN < vt.size(); h++) begin
      checks++;
      if (vt[h * ROWLEN] - hs_t[h] != 4) begin
        errors++; $display("FAIL full_gap[%0d]: hsync_to_valid=%0d, required 4", h, vt[h * ROWLEN] - hs_t[h]);
      end
    end
    checks++;
    if (n_excl != 0 || n_rv != 0 || n_tz != 0) begin
      errors++; $display("FAIL full_protocol: overlap=%0d ready_valid=%0d nonzero_idle=%0d, required 0 0 0", n_excl, n_rv, n_tz);
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    run_frame(1'b1, -1);
    checks++;
    if (vd.size() != TOTAL * PASSES) begin
      errors++; $display("FAIL bp_valid: count=%0d, required %0d", vd.size(), TOTAL * PASSES);
    end
    for (int i = 0; i < vd.size() && i < TOTAL * PASSES; i++) begin
      checks++;
      if (vd[i] !== exp_word(i)) begin
        errors++; $display("FAIL bp_word[%0d]: got=%h, required %h", i, vd[i], exp_word(i));
      end
    end
    checks++;
    if (n_rv != 0 || n_done != 1) begin
      errors++; $display("FAIL bp_protocol: ready_valid=%0d done=%0d, required 0 1", n_rv, n_done);
    end
  endtask

  task automatic test_ignored_start();
    sel = 1'b0;
    run_frame(1'b0, 20);
    checks++;
    if (n_vs != 1) begin errors++; $display("FAIL ign_vsync: count=%0d, required 1", n_vs); end
    checks++;
    if (n_done != 1 || vd.size() != TOTAL * PASSES) begin
      errors++; $display("FAIL ign_frame: done=%0d beats=%0d, required 1 %0d", n_done, vd.size(), TOTAL * PASSES);
    end
    for (int i = 0; i < vd.size() && i < TOTAL * PASSES; i += 5) begin
      checks++;
      if (vd[i] !== exp_word(i)) begin
        errors++; $display("FAIL ign_word[%0d]: got=%h, required %h", i, vd[i], exp_word(i));
      end
    end
  endtask

  task automatic test_gap0();
    sel = 1'b1;
    run_frame(1'b0, -1);
    checks++;
    if (hs_t.size() != NROWS * PASSES || vd.size() != TOTAL * PASSES) begin
      errors++; $display("FAIL gap0_counts: hsync=%0d beats=%0d, required %0d %0d", hs_t.size(), vd.size(), NROWS * PASSES, TOTAL * PASSES);
    end
    for (int h = 0; h < hs_t.size() && h * ROWLEN < vt.size(); h++) begin
      checks++;
      if (vt[h * ROWLEN] - hs_t[h] != 2) begin
        errors++; $display("FAIL gap0_latency[%0d]: hsync_to_valid=%0d, required 2", h, vt[h * ROWLEN] - hs_t[h]);
      end
    end
    checks++;
    if (n_tz != 0) begin errors++; $display("FAIL gap0_idle_data: nonzero_idle=%0d, required 0", n_tz); end
    for (int i = 0; i < vd.size() && i < TOTAL * PASSES; i += 3) begin
      checks++;
      if (vd[i] !== exp_word(i)) begin
        errors++; $display("FAIL gap0_word[%0d]: got=%h, required %h", i, vd[i], exp_word(i));
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reuse();
    sel = 1'b0;
    run_frame(1'b1, -1);
    checks++;
    if (hs_t.size() != NROWS * PASSES || n_done != 1) begin
      errors++; $display("FAIL reuse_counts: hsync=%0d done=%0d, required %0d 1", hs_t.size(), n_done, NROWS * PASSES);
    end
    for (int i = 0; i < vr.size() && i < TOTAL * PASSES; i++) begin
      checks++;
      if (vr[i] != ((i / ROWLEN) % PASSES == 1)) begin
        errors++; $display("FAIL reuse_flag[%0d]: got=%0d, required %0d", i, vr[i], ((i / ROWLEN) % PASSES == 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_ignored_start();
    test_gap0();
    test_reuse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
